// File: rtl/imem_program_loader.sv
`timescale 1ns/1ps
// imem_program_loader
//   Receives program frames from a host byte stream and writes them into the
//   core's instruction memory. The core is held (PC at 0) from the start of a
//   frame until a frame's checksum verifies.
//   Frame: SYNC, CNT_HI, CNT_LO, N x {HI, LO}, CHK (XOR of the 2N data bytes).
// Ports:
//   clk, reset (async, active low)
//   in_data/in_valid/in_ready  host byte stream (never back-pressured)
//   imem_we/imem_addr/imem_wdata  instruction-memory write port (registered)
//   core_hold                  core stall
//   load_done/load_error       status of the last frame (levels)
//   words_loaded               words written in the current/last frame
module imem_program_loader #(
    parameter int          ADDR_W        = 8,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int          TIMEOUT       = 1024,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          TW  = $clog2(TIMEOUT + 1);
    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          chk_q, chk_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     wl_q, wl_d;

    logic        accept, in_frame, tmo_hit, is_sync, cnt_over, cnt_zero, last_word, chk_ok;
    logic [15:0] cnt_full;

    assign in_ready  = 1'b1;
    assign accept    = in_valid;
    assign is_sync   = (in_data == SYNC_BYTE);
    assign in_frame  = (state_q inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK});
    // Fires on the TIMEOUT-th consecutive idle cycle inside a frame.
    assign tmo_hit   = in_frame && !accept && (tmo_q == TW'(TIMEOUT - 1));
    assign cnt_full  = {count_q[15:8], in_data};
    assign cnt_over  = ({1'b0, cnt_full} > CAP);
    assign cnt_zero  = (cnt_full == 16'd0);
    assign last_word = ((17'(wl_q) + 17'd1) == {1'b0, count_q});
    assign chk_ok    = (in_data == chk_q);

    // State register plus datapath/output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= HOLD_AT_RESET;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wl_q    <= wl_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = S_ERROR;
        end else if (accept) begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: if (is_sync) state_d = S_CNT_HI;
                S_CNT_HI:  state_d = S_CNT_LO;
                S_CNT_LO:  state_d = cnt_over ? S_ERROR : (cnt_zero ? S_CHECK : S_DATA_HI);
                S_DATA_HI: state_d = S_DATA_LO;
                S_DATA_LO: state_d = last_word ? S_CHECK : S_DATA_HI;
                S_CHECK:   state_d = chk_ok ? S_DONE : S_ERROR;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        count_d = count_q;
        hi_d    = hi_q;
        chk_d   = chk_q;
        tmo_d   = (in_frame && !accept) ? tmo_q + 1'b1 : '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        wl_d    = wl_q;
        if (tmo_hit) begin
            tmo_d  = '0;
            err_d  = 1'b1;
            hold_d = 1'b1;
        end else if (accept) begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (is_sync) begin
                        hold_d = 1'b1;
                        done_d = 1'b0;
                        err_d  = 1'b0;
                        wl_d   = '0;
                        chk_d  = '0;
                    end
                end
                S_CNT_HI: count_d[15:8] = in_data;
                S_CNT_LO: begin
                    count_d[7:0] = in_data;
                    if (cnt_over) err_d = 1'b1;
                end
                S_DATA_HI: begin
                    hi_d  = in_data;
                    chk_d = chk_q ^ in_data;
                end
                S_DATA_LO: begin
                    chk_d   = chk_q ^ in_data;
                    we_d    = 1'b1;
                    addr_d  = wl_q[ADDR_W-1:0];
                    wdata_d = {hi_q, in_data};
                    wl_d    = wl_q + 1'b1;
                end
                S_CHECK: begin
                    if (chk_ok) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_hold    = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = wl_q;

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writes programs into the 16-bit pipelined core's instruction memory from a host byte stream.
- It is the write-side counterpart of the fetch stage's instruction-memory read path.
- Holds the core stalled while a frame is received and released only after the frame's checksum verifies.
- Sits between a host link (UART receiver or bench driver) and the instruction-memory write port.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1024, idle cycles allowed between bytes inside a frame before the frame is aborted.
- HOLD_AT_RESET, 1, sets the core_hold value driven during and after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  host byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both 1.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  16  instruction word.
- core_hold  out  1  stalls the core and keeps its PC at 0 while 1.
- load_done  out  1  last frame verified; level signal.
- load_error  out  1  last frame failed; level signal.
- words_loaded  out  ADDR_W+1  words written in the current or last frame.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_hold=HOLD_AT_RESET, load_done=0, load_error=0, words_loaded=0.
  - The count, checksum and timeout registers clear.
- Frame format: SYNC, CNT_HI, CNT_LO, then N words sent high byte first, then CHK.
  - CHK is the XOR of all 2N data bytes; header bytes are excluded.
- in_ready is 1 in every state; the loader never back-pressures. All state transitions occur only on an accepted byte, except on timeout.
- FSM states and transitions:
  - IDLE: a byte equal to SYNC goes to CNT_HI, sets core_hold=1, clears load_done, load_error, words_loaded and the checksum. Other bytes are discarded.
  - CNT_HI: latch count[15:8]; go to CNT_LO.
  - CNT_LO: latch count[7:0].
    - count > 2^ADDR_W: go to ERROR.
    - count == 0: go to CHECK.
    - otherwise: go to DATA_HI.
  - DATA_HI: latch the high byte; XOR it into the checksum; go to DATA_LO.
  - DATA_LO: XOR the byte into the checksum; go to DATA_HI, or to CHECK after the last word.
    - On the next edge: imem_we=1 for exactly one cycle, imem_wdata={hi,lo}, imem_addr=word index starting at 0.
    - words_loaded increments in that same cycle.
  - CHECK: compare the byte to the checksum.
    - Match: go to DONE; load_done=1, core_hold=0.
    - Mismatch: go to ERROR; load_error=1, core_hold stays 1.
  - DONE and ERROR: outputs hold. A SYNC byte starts a new frame exactly as in IDLE; non-SYNC bytes are discarded.
- Timeout: in CNT_HI through CHECK, the counter increments on each cycle without an accepted byte and clears on every accepted byte. Reaching TIMEOUT forces ERROR (load_error=1, core_hold=1).
- Words already written before an error remain in memory; the core is not released until a later frame verifies.
- Address wrap is impossible because count is bounded by 2^ADDR_W. count == 2^ADDR_W is legal and ends with imem_addr = 2^ADDR_W − 1.
- Reset asserted mid-frame aborts immediately to the reset values. Partial memory contents are not cleared.
- A SYNC-valued byte inside a frame is treated as data.
- Latency: the final byte (CHK) is accepted on edge k; core_hold falls and load_done rises at edge k.

Test Plan:
- Reset with HOLD_AT_RESET=1, then frame A5 00 02 12 34 AB CD 40 -> two write pulses: (0,1234), (1,ABCD); words_loaded=2; load_done=1, core_hold=0 on the CHK edge.
- Same frame with CHK=41 -> both words written; load_error=1, load_done=0, core_hold=1.
- Bytes 00 FF A5 00 00 00 -> the first two bytes are ignored; zero writes; load_done=1.
- A5 01 01 (count 257 with ADDR_W=8) -> ERROR after CNT_LO; no writes; load_error=1.
- A5 00 01 12, then idle for TIMEOUT cycles -> load_error=1; a following valid frame recovers to load_done=1.
- Drive reset low during DATA_LO of a 3-word frame -> imem_we=0, words_loaded=0, state IDLE; the next full frame loads correctly.
